uart_byte_sink: RTL and testbench
=================================

UART_BYTE_SINK -- requirements
Module: uart_byte_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the receive FIFO depth in bytes (power of two, 2..64).
REQ-002 SHALL have parameter LVL_W, default 4, meaning the width of level (log2(FIFO_DEPTH)+1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is in this domain.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rxd, input, 1, serial line from the SoC uart0_tx/uart1_tx pin (asynchronous, idle high).
REQ-006 SHALL have port baud_div, input, 16, clocks per bit; values below 4 are treated as 4.
REQ-007 SHALL have port m_data, output, 8, the byte at the FIFO head.
REQ-008 SHALL have port m_valid, output, 1, high when the FIFO is non-empty.
REQ-009 SHALL have port m_ready, input, 1, consumer accepts m_data when m_valid and m_ready are high.
REQ-010 SHALL have port level, output, LVL_W, number of bytes held in the FIFO.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse when a stop bit samples low.
REQ-012 SHALL have port overflow, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer (both flops reset to 1), plus one further delay flop for edge detection.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: on a synchronized falling edge, latch eff_div = max(baud_div,4), load the bit counter with eff_div>>1, and go to START.
REQ-016 START: on counter expiry, sample rxd. If high, return to IDLE (glitch, no error). If low, reload eff_div, set bit index 0, and go to DATA.
REQ-017 DATA: every eff_div cycles, sample one bit into the shift register LSB-first; after bit 7, reload eff_div and go to STOP.
REQ-018 STOP: after eff_div cycles, sample rxd.
- High: push the byte and go to IDLE.
- Low: pulse frame_err, drop the byte, go to BREAK.
REQ-019 BREAK: stay until synchronized rxd is high, then go to IDLE; no start edge is recognised while in BREAK.
REQ-020 baud_div changes after start detection SHALL NOT affect the frame in progress.
REQ-021 FIFO SHALL be first-word-fall-through.
- m_data/m_valid are updated in the cycle after a push into an empty FIFO.
- m_data is undefined while m_valid is low.
REQ-022 A pop occurs when m_valid&&m_ready; the head advances in the next cycle.
REQ-023 A push is accepted when level<FIFO_DEPTH, or when a pop occurs in the same cycle.
- Push and pop together leave level unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
REQ-024 A push attempted while full with no simultaneous pop SHALL pulse overflow; FIFO contents are unchanged.
REQ-025 m_ready while empty SHALL have no effect; level SHALL never exceed FIFO_DEPTH or underflow.
REQ-026 frame_err and overflow SHALL be registered and high for exactly one cycle per event.

Reset
REQ-027 rst SHALL asynchronously force:
- state=IDLE, counters=0, pointers=0;
- level=0, m_valid=0, frame_err=0, overflow=0;
- synchronizer flops=1.
REQ-028 rst asserted mid-frame SHALL discard the partial byte. After release, a line that is still low SHALL NOT be taken as a start bit until a high-to-low edge is seen.

Verification
REQ-029 baud_div=16, m_ready=1, send 0x55 with 1 stop bit -> m_valid high for 1 cycle with m_data=0x55, within 10*16+6 cycles of the start edge; frame_err=0.
REQ-030 baud_div=16, m_ready=0, send 9 bytes 0x01..0x09 -> level=8, overflow pulses once on byte 9; then popping yields 0x01..0x08 in order and level returns to 0.
REQ-031 Send 0xA3 with the stop bit held low for 40 bit-times, then idle, then send 0x3C -> frame_err pulses once, nothing is pushed for 0xA3, and m_data=0x3C is received.
REQ-032 rxd low pulse of 5 cycles with baud_div=16 -> START aborts back to IDLE; no push, no error.
REQ-033 FIFO full (level=8) with m_ready=1 held, and a new byte 0x7E completing in the same cycle as a pop -> no overflow, level stays 8, 0x7E is read last.
REQ-034 baud_div=2 while sending 0xF0 at 4 clocks/bit -> 0xF0 is received correctly; assert rst during bit 3 of a second byte -> no push, all outputs at reset values.

Source files
------------

// File: rtl/uart_byte_sink.sv
// UART receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO.
// Detects start edges on a synchronized line, samples mid-bit, and flags framing errors and drops.
module uart_byte_sink #(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    input  logic [15:0]      baud_div,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LVL_W-1:0] level,
    output logic             frame_err,
    output logic             overflow,
    output logic [2:0]       dbg_state
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [1:0]       warm_q, warm_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic [15:0] eff_div;
    logic        fall, expire, push, pop, full, wr_en;

    assign eff_div = (baud_div < 16'd4) ? 16'd4 : baud_div;
    // The edge detector only trusts prev_q once it holds a real line sample,
    // so a line held low through reset release is not mistaken for a start bit.
    assign fall    = (warm_q == 2'd3) && prev_q && !sync2_q;
    assign expire  = (cnt_q <= 16'd1);
    assign warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    div_d   = eff_div;
                    cnt_d   = eff_div >> 1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (expire) begin
                    if (sync2_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = div_q;
                        bit_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = div_q;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (expire) begin
                    if (sync2_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Consumer handshake: a byte transfers on any clock where m_valid && m_ready;
    // m_data is held stable while m_valid is high and not yet accepted.
    assign full       = (count_q == LVL_W'(FIFO_DEPTH));
    assign pop        = m_valid && m_ready;
    assign wr_en      = push && (!full || pop);
    assign overflow_d = push && full && !pop;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) count_d = count_q + LVL_W'(1);
        else if (!wr_en && pop) count_d = count_q - LVL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            warm_q      <= 2'd0;
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            div_q       <= 16'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            warm_q      <= warm_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign m_data    = mem_q[rd_ptr_q];
    assign m_valid   = (count_q != '0);
    assign level     = count_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_uart_byte_sink.sv
// Bench for uart_byte_sink: serial driver, expected-byte queue, and a monitor that
// pops and compares on each consumer handshake.
module tb_uart_byte_sink;
    localparam int DEPTH = 8;
    localparam int LVL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             rxd;
    logic [15:0]      baud_div;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic [LVL_W-1:0] level;
    logic             frame_err;
    logic             overflow;
    logic [2:0]       dbg_state;

    logic ready_val = 1'b0;
    logic rand_mode = 1'b0;
    logic rand_bit  = 1'b0;
    assign m_ready = rand_mode ? rand_bit : ready_val;

    uart_byte_sink #(.FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .baud_div(baud_div),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .frame_err(frame_err), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rand_bit <= 1'($urandom_range(0, 1));

    // scoreboard state
    logic [7:0] exp_q[$];
    int total = 0, bad = 0;
    int ferr_seen = 0, ovf_seen = 0, exp_ferr = 0, exp_ovf = 0;
    int valid_cycles = 0, pops = 0, last_pop_cyc = 0;
    logic [7:0] last_pop_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: samples 2 units after the falling edge, before the next rising edge
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (frame_err) ferr_seen++;
            if (overflow) ovf_seen++;
            if (m_valid) valid_cycles++;
            if (m_valid && m_ready) begin
                pops++;
                last_pop_cyc  = cyc;
                last_pop_data = m_data;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got 0x%0h expected no byte (t=%0t)", m_data, $time);
                end else begin
                    check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame; d is the true clocks per bit, cfg the value placed on baud_div.
    // stop_low > 0 holds the stop bit low for that many bit times.
    task automatic send_frame(input logic [7:0] b, input logic [15:0] cfg, input int d,
                              input int stop_low, input bit pop_coincides);
        baud_div = cfg;
        rxd = 1'b0;
        repeat (d) @(negedge clk);
        baud_div = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (d) @(negedge clk);
        end
        if (stop_low == 0) begin
            if (exp_q.size() < DEPTH || pop_coincides) exp_q.push_back(b);
            else exp_ovf++;
            rxd = 1'b1;
            repeat (d) @(negedge clk);
        end else begin
            exp_ferr++;
            rxd = 1'b0;
            repeat (d * stop_low) @(negedge clk);
            rxd = 1'b1;
            repeat (d) @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 600 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_level_zero"}, 32'(level), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_level"}, 32'(level), 32'd0);
        check({name, "_m_valid"}, 32'(m_valid), 32'd0);
        check({name, "_frame_err"}, 32'(frame_err), 32'd0);
        check({name, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc;
        int pops_before;
        logic [7:0] b;
        logic [7:0] second;
        logic [15:0] cfg;
        int d;

        rxd = 1'b1;
        baud_div = 16'd16;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(10);

        // single byte, latency from the start edge and a one-cycle valid
        ready_val = 1'b1;
        valid_cycles = 0;
        start_cyc = cyc;
        send_frame(8'h55, 16'd16, 16, 0, 1'b0);
        idle(20);
        check("lat_within_166", 32'((last_pop_cyc - start_cyc) <= 166), 32'd1);
        check("valid_one_cycle", 32'(valid_cycles), 32'd1);
        check("no_frame_err_55", 32'(ferr_seen), 32'(exp_ferr));
        check("byte55_taken", 32'(exp_q.size()), 32'd0);

        // nine bytes with no consumer: eight stored, ninth dropped
        ready_val = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 16'd16, 16, 0, 1'b0);
            idle(3);
        end
        idle(10);
        check("full_level", 32'(level), 32'(exp_q.size()));
        check("overflow_once", 32'(ovf_seen), 32'(exp_ovf));
        ready_val = 1'b1;
        drain("ovf_drain");

        // stop bit held low, then a clean byte
        send_frame(8'hA3, 16'd16, 16, 40, 1'b0);
        idle(50);
        send_frame(8'h3C, 16'd16, 16, 0, 1'b0);
        idle(20);
        check("frame_err_once", 32'(ferr_seen), 32'(exp_ferr));
        check("last_byte_3c", 32'(last_pop_data), 32'h3C);
        drain("ferr_drain");

        // 5-cycle glitch must abort in START
        pops_before = pops;
        baud_div = 16'd16;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        idle(300);
        check("glitch_no_pop", 32'(pops), 32'(pops_before));
        check("glitch_no_err", 32'(ferr_seen), 32'(exp_ferr));
        check("glitch_level", 32'(level), 32'd0);

        // full FIFO, pop lands on the same cycle as the new byte's push
        ready_val = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'($urandom_range(0, 255)), 16'd16, 16, 0, 1'b0);
            idle(3);
        end
        fork
            send_frame(8'h7E, 16'd16, 16, 0, 1'b1);
            begin
                repeat (2 + 8 + 9 * 16) @(negedge clk);
                ready_val = 1'b1;
                @(negedge clk);
                ready_val = 1'b0;
            end
        join
        idle(10);
        check("coincide_level", 32'(level), 32'(exp_q.size()));
        check("coincide_no_ovf", 32'(ovf_seen), 32'(exp_ovf));
        ready_val = 1'b1;
        drain("coincide_drain");
        check("coincide_last_7e", 32'(last_pop_data), 32'h7E);

        // random bytes, rates and consumer stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            cfg = 16'($urandom_range(0, 24));
            d = (cfg < 16'd4) ? 4 : int'(cfg);
            send_frame(b, cfg, d, 0, 1'b0);
            idle($urandom_range(0, 10));
        end
        rand_mode = 1'b0;
        ready_val = 1'b1;
        drain("rand_drain");

        // baud_div below the floor, then reset in the middle of a frame
        send_frame(8'hF0, 16'd2, 4, 0, 1'b0);
        idle(10);
        check("f0_received", 32'(last_pop_data), 32'hF0);
        check("f0_drained", 32'(exp_q.size()), 32'd0);
        pops_before = pops;
        second = 8'hA5;
        baud_div = 16'd2;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = second[i];
            repeat (4) @(negedge clk);
        end
        rxd = second[3];
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midframe_rst");
        rst = 1'b0;
        repeat (30) @(negedge clk);
        idle(60);
        check("rst_no_pop", 32'(pops), 32'(pops_before));
        check("rst_no_err", 32'(ferr_seen), 32'(exp_ferr));
        check("rst_level", 32'(level), 32'd0);
        send_frame(8'h5A, 16'd16, 16, 0, 1'b0);
        idle(20);
        check("after_rst_5a", 32'(last_pop_data), 32'h5A);

        drain("final");
        check("final_frame_err", 32'(ferr_seen), 32'(exp_ferr));
        check("final_overflow", 32'(ovf_seen), 32'(exp_ovf));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
